// File: rtl/mem_responder_multi_if.sv
// mem_responder_multi_if
//   Bus between the multicycle control/datapath and the memory responder.
//   The strobe, address, store data and funct3 come from the datapath side;
//   the load data and status flags come back from the responder.
//
//   Signals:
//     iMemRead / iMemWrite : level strobes from the control FSM
//     iAddress             : byte address (already muxed by IouD)
//     iWriteData           : store data from the B register, right-aligned
//     iFunct3              : RV32I load/store funct3 (size and sign)
//     oReadData            : formatted load data, held until the next read completes
//     oReady               : one-cycle completion pulse
//     oBusy                : high from accept to completion inclusive
//     oMisaligned          : pulses with oReady when the access was aborted
//     oOverrun             : sticky, a request edge was dropped
//
//   Modports: master (datapath side), slave (responder side).
interface mem_responder_multi_if;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic [2:0]  iFunct3;
    logic [31:0] oReadData;
    logic        oReady;
    logic        oBusy;
    logic        oMisaligned;
    logic        oOverrun;

    modport master (
        output iMemRead, iMemWrite, iAddress, iWriteData, iFunct3,
        input  oReadData, oReady, oBusy, oMisaligned, oOverrun
    );

    modport slave (
        input  iMemRead, iMemWrite, iAddress, iWriteData, iFunct3,
        output oReadData, oReady, oBusy, oMisaligned, oOverrun
    );
endinterface

// File: rtl/mem_responder_multi.sv
// mem_responder_multi
//   Memory-side responder for the multicycle datapath. Turns the control
//   FSM's level strobes into single requests (rising-edge detect), services
//   byte/half/word accesses from an internal word RAM after WAIT_CYCLES
//   wait states, and reports completion with a one-cycle oReady pulse.
//
//   Parameters:
//     ADDR_W      : word-address width, RAM holds 2**ADDR_W 32-bit words
//     WAIT_CYCLES : extra wait cycles between accept and completion (0..15)
//     INIT_FILE   : hex file loaded into RAM at elaboration ("" = no load)
//
//   Ports:
//     iCLK : clock
//     iRST : asynchronous, active-high reset
//     bus  : mem_responder_multi_if.slave (strobes, address, data, funct3,
//            load data, oReady/oBusy/oMisaligned/oOverrun)
//
//   Optional feature (macro MEM_RESPONDER_COUNT_EN):
//     oReadCount / oWriteCount : saturating counts of completed,
//     non-misaligned reads and writes.
module mem_responder_multi #(
    parameter int    ADDR_W      = 10,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    mem_responder_multi_if.slave  bus
`ifdef MEM_RESPONDER_COUNT_EN
    ,
    output logic [15:0]           oReadCount,
    output logic [15:0]           oWriteCount
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                rd_q;
    logic                wr_q;
    logic                isWrite_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         data_q;
    logic [2:0]          funct3_q;
    logic [31:0]         readData_q;
    logic                ready_q;
    logic                busy_q;
    logic                misaligned_q;
    logic                overrun_q;

    logic [31:0]         mem [2**ADDR_W];

    logic                rdEdge;
    logic                wrEdge;
    logic                anyEdge;
    logic                enterDone;
    logic [ADDR_W+1:0]   opAddr;
    logic [31:0]         opData;
    logic [2:0]          opFunct3;
    logic                opWrite;
    logic                isByte;
    logic                isHalf;
    logic                misaligned;
    logic [31:0]         ramWord;
    logic [31:0]         readData_d;
    logic [31:0]         memWord_d;
    logic [7:0]          laneByte;
    logic [15:0]         laneHalf;
    logic                ramWe;
    logic                unusedAddrBits;

    assign rdEdge  = bus.iMemRead & ~rd_q;
    assign wrEdge  = bus.iMemWrite & ~wr_q;
    assign anyEdge = rdEdge | wrEdge;

    // With WAIT_CYCLES == 0 the access completes on the accept edge itself,
    // so in IDLE the operation is taken straight from the bus instead of the
    // latches, which are only being loaded on that same edge.
    assign opAddr   = (state_q == IDLE) ? bus.iAddress[ADDR_W+1:0] : addr_q;
    assign opData   = (state_q == IDLE) ? bus.iWriteData : data_q;
    assign opFunct3 = (state_q == IDLE) ? bus.iFunct3 : funct3_q;
    assign opWrite  = (state_q == IDLE) ? wrEdge : isWrite_q;

    assign unusedAddrBits = ^bus.iAddress[31:ADDR_W+2];

    // funct3 4/5 are LBU/LHU for loads but unknown (treated as SW) for stores.
    assign isByte     = (opFunct3[1:0] == 2'b00) & (~opWrite | ~opFunct3[2]);
    assign isHalf     = (opFunct3[1:0] == 2'b01) & (~opWrite | ~opFunct3[2]);
    assign misaligned = (isHalf & opAddr[0]) | (~isByte & ~isHalf & (opAddr[1:0] != 2'b00));

    assign enterDone = ((state_q == IDLE) && anyEdge && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0));

    assign ramWord = mem[opAddr[ADDR_W+1:2]];
    assign ramWe   = enterDone & opWrite & ~misaligned & ~iRST;

    // Load formatting and store byte-lane merge of the addressed RAM word.
    always_comb begin
        laneByte   = ramWord[{opAddr[1:0], 3'b000} +: 8];
        laneHalf   = ramWord[{opAddr[1], 4'b0000} +: 16];
        readData_d = ramWord;
        case (opFunct3)
            3'd0:    readData_d = {{24{laneByte[7]}}, laneByte};
            3'd4:    readData_d = {24'd0, laneByte};
            3'd1:    readData_d = {{16{laneHalf[15]}}, laneHalf};
            3'd5:    readData_d = {16'd0, laneHalf};
            default: readData_d = ramWord;
        endcase

        memWord_d = ramWord;
        if (isByte) begin
            memWord_d[{opAddr[1:0], 3'b000} +: 8] = opData[7:0];
        end else if (isHalf) begin
            memWord_d[{opAddr[1], 4'b0000} +: 16] = opData[15:0];
        end else begin
            memWord_d = opData;
        end
    end

    // RAM contents survive reset, so the array sits outside the reset domain.
    always_ff @(posedge iCLK) begin
        if (ramWe) begin
            mem[opAddr[ADDR_W+1:2]] <= memWord_d;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            isWrite_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= 32'd0;
            funct3_q     <= 3'd0;
            readData_q   <= 32'd0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            misaligned_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rd_q         <= bus.iMemRead;
            wr_q         <= bus.iMemWrite;
            ready_q      <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyEdge) begin
                        // Simultaneous edges: the write wins, the read is lost.
                        if (rdEdge && wrEdge) begin
                            overrun_q <= 1'b1;
                        end
                        addr_q    <= bus.iAddress[ADDR_W+1:0];
                        data_q    <= bus.iWriteData;
                        funct3_q  <= bus.iFunct3;
                        isWrite_q <= wrEdge;
                        busy_q    <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (anyEdge) begin
                        overrun_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (anyEdge) begin
                        overrun_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            if (enterDone) begin
                ready_q      <= 1'b1;
                misaligned_q <= misaligned;
                if (!opWrite && !misaligned) begin
                    readData_q <= readData_d;
                end
            end
        end
    end

    assign bus.oReadData   = readData_q;
    assign bus.oReady      = ready_q;
    assign bus.oBusy       = busy_q;
    assign bus.oMisaligned = misaligned_q;
    assign bus.oOverrun    = overrun_q;

`ifdef MEM_RESPONDER_COUNT_EN
    logic [15:0] readCount_q;
    logic [15:0] writeCount_q;

    // isWrite_q stays valid through DONE, so it tells which counter to bump.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            readCount_q  <= 16'd0;
            writeCount_q <= 16'd0;
        end else if (ready_q && !misaligned_q) begin
            if (isWrite_q) begin
                if (writeCount_q != 16'hFFFF) begin
                    writeCount_q <= writeCount_q + 16'd1;
                end
            end else begin
                if (readCount_q != 16'hFFFF) begin
                    readCount_q <= readCount_q + 16'd1;
                end
            end
        end
    end

    assign oReadCount  = readCount_q;
    assign oWriteCount = writeCount_q;
`endif

endmodule

// File: tb/tb_mem_responder_multi.sv
// tb_mem_responder_multi
//   Drives three responders (WAIT_CYCLES 0, 1 and 3, ADDR_W 6) with the same
//   request stream and compares each one cycle by cycle against a byte-level
//   memory model kept per instance. Counter outputs are checked when the
//   build defines MEM_RESPONDER_COUNT_EN.
module tb_mem_responder_multi;
    localparam int N     = 3;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic           clk;
    logic [N-1:0]   rst;
    logic           memRead;
    logic           memWrite;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [2:0]     funct3;

    logic [31:0]    rdDataV [N];
    logic           readyV  [N];
    logic           busyV   [N];
    logic           misV    [N];
    logic           ovV     [N];
`ifdef MEM_RESPONDER_COUNT_EN
    logic [15:0]    rdCntV  [N];
    logic [15:0]    wrCntV  [N];
`endif

    int             compared   = 0;
    int             mismatched = 0;

    logic [31:0]    modelMem [N][DEPTH];
    logic [31:0]    expRd    [N];
    bit             expOv    [N];
    int             expRc    [N];
    int             expWc    [N];

    function automatic int waitOf(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : gDut
            mem_responder_multi_if bus();
            assign bus.iMemRead   = memRead;
            assign bus.iMemWrite  = memWrite;
            assign bus.iAddress   = addr;
            assign bus.iWriteData = wdata;
            assign bus.iFunct3    = funct3;

            mem_responder_multi #(
                .ADDR_W      (AW),
                .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
                .INIT_FILE   ("")
            ) dut (
                .iCLK        (clk),
                .iRST        (rst[g]),
                .bus         (bus)
`ifdef MEM_RESPONDER_COUNT_EN
                ,
                .oReadCount  (rdCntV[g]),
                .oWriteCount (wrCntV[g])
`endif
            );

            assign rdDataV[g] = bus.oReadData;
            assign readyV[g]  = bus.oReady;
            assign busyV[g]   = bus.oBusy;
            assign misV[g]    = bus.oMisaligned;
            assign ovV[g]     = bus.oOverrun;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access size in bytes from the RV32I load/store encoding.
    function automatic int accessBytes(input bit wr, input logic [2:0] f3);
        if (f3 == 3'd0 || (!wr && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (!wr && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] a,
                                              input logic [2:0] f3);
        logic [31:0] v;
        int          sh;
        case (f3)
            3'd0, 3'd4: begin
                sh = int'(a[1:0]) * 8;
                v  = (word >> sh) & 32'h0000_00FF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                sh = int'(a[1]) * 16;
                v  = (word >> sh) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [31:0] a,
                                               input logic [31:0] d, input logic [2:0] f3);
        int          n;
        int          sh;
        logic [31:0] m;
        n  = accessBytes(1'b1, f3);
        sh = int'(a[1:0]) * 8;
        m  = 32'(((64'd1 << (8 * n)) - 64'd1) << sh);
        return (old & ~m) | ((d << sh) & m);
    endfunction

    task automatic modelOp(input int i, input bit wr, input bit both, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3, output bit mis);
        int idx;
        idx = int'(a[AW+1:2]);
        mis = (int'(a[1:0]) % accessBytes(wr, f3)) != 0;
        if (both) expOv[i] = 1'b1;
        if (!mis) begin
            if (wr) begin
                modelMem[i][idx] = modelStore(modelMem[i][idx], a, d, f3);
                expWc[i]++;
            end else begin
                expRd[i] = modelLoad(modelMem[i][idx], a, f3);
                expRc[i]++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input int i, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s dut%0d: observed %h expected %h", tag, i, got, exp);
        end
    endtask

    task automatic checkCycle(input int i, input int k, input bit mis,
                              input logic [31:0] oldRd, input logic [31:0] newRd);
        int lat;
        lat = waitOf(i) + 1;
        checkOutput("oReady", i, 32'(readyV[i]), 32'(k == lat));
        checkOutput("oBusy", i, 32'(busyV[i]), 32'(k <= lat));
        checkOutput("oMisaligned", i, 32'(misV[i]), 32'((k == lat) && mis));
        checkOutput("oReadData", i, rdDataV[i], (k >= lat) ? newRd : oldRd);
        checkOutput("oOverrun", i, 32'(ovV[i]), 32'(expOv[i]));
    endtask

    task automatic checkCounts(input int i);
`ifdef MEM_RESPONDER_COUNT_EN
        checkOutput("oReadCount", i, 32'(rdCntV[i]), 32'(expRc[i]));
        checkOutput("oWriteCount", i, 32'(wrCntV[i]), 32'(expWc[i]));
`else
        if (i < 0) $display("[TB] counters not built");
`endif
    endtask

    task automatic checkReset(input int i);
        checkOutput("rst oReady", i, 32'(readyV[i]), 32'd0);
        checkOutput("rst oBusy", i, 32'(busyV[i]), 32'd0);
        checkOutput("rst oMisaligned", i, 32'(misV[i]), 32'd0);
        checkOutput("rst oOverrun", i, 32'(ovV[i]), 32'd0);
        checkOutput("rst oReadData", i, rdDataV[i], 32'd0);
        checkCounts(i);
    endtask

    task automatic clearModelState(input int i);
        expRd[i] = 32'd0;
        expOv[i] = 1'b0;
        expRc[i] = 0;
        expWc[i] = 0;
    endtask

    // One request presented at a negedge; wr selects write (rd alongside it
    // only creates a dropped read). Strobes are held for 'hold' cycles.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] a,
                                 input logic [31:0] d, input logic [2:0] f3, input int hold);
        logic [31:0] oldRd [N];
        bit          mis;
        for (int i = 0; i < N; i++) begin
            oldRd[i] = expRd[i];
            modelOp(i, wr, wr && rd, a, d, f3, mis);
        end
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        funct3   = f3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == hold) begin
                memRead  = 1'b0;
                memWrite = 1'b0;
            end
            for (int i = 0; i < N; i++) checkCycle(i, k, mis, oldRd[i], expRd[i]);
        end
        for (int i = 0; i < N; i++) checkCounts(i);
    endtask

    // Aligned access interrupted by reset on instances 1 and 2 while they
    // are in their wait states; instance 0 has already completed.
    task automatic resetDuringOp(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f3);
        bit mis;
        modelOp(0, wr, 1'b0, a, d, f3, mis);
        memRead  = ~wr;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        funct3   = f3;
        @(negedge clk);
        memRead  = 1'b0;
        memWrite = 1'b0;
        checkOutput("oReady no-wait", 0, 32'(readyV[0]), 32'd1);
        rst[2:1] = 2'b11;
        #1;
        for (int i = 1; i < N; i++) begin
            clearModelState(i);
            checkReset(i);
        end
        @(negedge clk);
        rst = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic resetAll();
        rst = '1;
        #1;
        for (int i = 0; i < N; i++) begin
            clearModelState(i);
            checkReset(i);
        end
        @(negedge clk);
        rst = '0;
        @(negedge clk);
    endtask

    initial begin
        bit          rw;
        bit          rr;
        logic [31:0] ra;
        logic [31:0] rdat;
        logic [2:0]  rf;
        int          rh;

        rst      = '1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        funct3   = 3'd0;
        for (int i = 0; i < N; i++) clearModelState(i);
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) checkReset(i);
        rst = '0;
        @(negedge clk);

        $display("[TB] preload RAM");
        for (int w = 0; w < DEPTH; w++) begin
            rdat = $urandom;
            applyStimulus(1'b1, 1'b0, 32'(w * 4), rdat, 3'd2, 1);
        end

        $display("[TB] word store/load");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'd2, 1);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'd0, 3'd2, 1);
        checkOutput("LW const", 1, rdDataV[1], 32'hDEADBEEF);

        $display("[TB] byte store/loads");
        applyStimulus(1'b1, 1'b0, 32'h21, 32'h80, 3'd0, 1);
        applyStimulus(1'b0, 1'b1, 32'h21, 32'd0, 3'd0, 1);
        checkOutput("LB const", 1, rdDataV[1], 32'hFFFFFF80);
        applyStimulus(1'b0, 1'b1, 32'h21, 32'd0, 3'd4, 1);
        checkOutput("LBU const", 1, rdDataV[1], 32'h00000080);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'd0, 3'd2, 1);

        $display("[TB] misaligned accesses");
        applyStimulus(1'b0, 1'b1, 32'h13, 32'd0, 3'd1, 1);
        applyStimulus(1'b1, 1'b0, 32'h12, 32'h55AA55AA, 3'd2, 1);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'd0, 3'd2, 1);

        $display("[TB] held read strobe");
        applyStimulus(1'b0, 1'b1, 32'h10, 32'd0, 3'd2, 3);

        $display("[TB] reset during wait");
        resetDuringOp(1'b0, 32'h10, 32'd0, 3'd2);
        resetDuringOp(1'b1, 32'h30, 32'hCAFEF00D, 3'd2);
        applyStimulus(1'b0, 1'b1, 32'h30, 32'd0, 3'd2, 1);

        $display("[TB] simultaneous read/write edges");
        resetAll();
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678, 3'd2, 1);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'd0, 3'd2, 1);

        $display("[TB] random accesses");
        for (int n = 0; n < 120; n++) begin
            rw   = 1'($urandom_range(0, 1));
            rr   = !rw || ($urandom_range(0, 5) == 0);
            ra   = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            rdat = $urandom;
            rf   = 3'($urandom_range(0, 7));
            rh   = $urandom_range(1, 3);
            applyStimulus(rw, rr, ra, rdat, rf, rh);
        end

        resetAll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
